// File: rtl/mbgd_pkg.sv
// Shared FSM state type and width helpers for the MBGD batch controller.
package mbgd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  function automatic int sum_w(input int dw, input int n_bit);
    return 2 * dw + n_bit;
  endfunction

  function automatic int acc_w(input int dw, input int n_bit, input int batch_log2);
    return sum_w(dw, n_bit) + batch_log2;
  endfunction

endpackage

// File: rtl/mbgd_batch_acc.sv
// Batch accumulator: adds the adder's row sum one cycle after each accepted row and
// latches the truncated batch mean on request; clear overrides every other control.
module mbgd_batch_acc
  import mbgd_pkg::*;
#(
  parameter int  DW         = 8,
  parameter int  N_bit      = 3,
  parameter int  BATCH_LOG2 = 2,
  localparam int SUM_W      = sum_w(DW, N_bit),
  localparam int ACC_W      = acc_w(DW, N_bit, BATCH_LOG2)
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_add,
  input  logic             i_acc_clr,
  input  logic             i_latch,
  input  logic [SUM_W-1:0] i_sum,
  output logic [SUM_W-1:0] o_grad
);

  logic             r_pend;
  logic [ACC_W-1:0] r_acc;
  logic [SUM_W-1:0] r_grad;
  logic [ACC_W-1:0] w_acc_next;

  // The adder's sum lags its enable by one cycle, so pend delays the add to match.
  assign w_acc_next = r_pend ? (r_acc + ACC_W'(i_sum)) : r_acc;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_pend <= 1'b0;
      r_acc  <= '0;
      r_grad <= '0;
    end else begin
      r_pend <= i_add;
      r_acc  <= i_acc_clr ? '0 : w_acc_next;
      if (i_latch) begin
        r_grad <= w_acc_next[ACC_W-1:BATCH_LOG2];
      end
    end
  end

  assign o_grad = r_grad;

endmodule

// File: rtl/mbgd_batch_ctrl.sv
// Sequences the MBGD row adder across one mini-batch and emits the batch mean.
// out_valid rises 2 cycles after the last row; in_ready stays low until the result is taken.
module mbgd_batch_ctrl
  import mbgd_pkg::*;
#(
  parameter int  N          = 8,
  parameter int  N_bit      = 3,
  parameter int  DW         = 8,
  parameter int  BATCH_LOG2 = 2,
  localparam int GROW_W     = (N_bit >= $clog2(N)) ? N_bit : $clog2(N),
  localparam int SUM_W      = sum_w(DW, GROW_W),
  localparam int CNT_W      = BATCH_LOG2 + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_abort,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_add_enable,
  output logic             o_add_reset,
  input  logic [SUM_W-1:0] i_add_sum,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [SUM_W-1:0] o_out_grad,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] BATCH = CNT_W'(1) << BATCH_LOG2;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;

  logic             w_clr;
  logic             w_hs;
  logic             w_out_hs;
  logic             w_latch;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_clr        = i_reset | i_abort;
  assign o_in_ready   = ~w_clr & ((r_state == ST_IDLE) | (r_state == ST_ACCUM));
  assign w_hs         = i_in_valid & o_in_ready;
  assign o_add_enable = w_hs;
  assign o_add_reset  = w_clr;
  assign w_out_hs     = r_out_valid & i_out_ready;
  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_latch      = (r_state == ST_DRAIN);
  assign o_out_valid  = r_out_valid;
  assign o_busy       = (r_state != ST_IDLE);

  // IDLE holds cnt at zero, so it shares the accept path with ACCUM.
  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (w_hs) begin
            r_cnt   <= w_cnt_inc;
            r_state <= (w_cnt_inc == BATCH) ? ST_DRAIN : ST_ACCUM;
          end
        end
        ST_DRAIN: begin
          r_out_valid <= 1'b1;
          r_state     <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  mbgd_batch_acc #(
    .DW         (DW),
    .N_bit      (GROW_W),
    .BATCH_LOG2 (BATCH_LOG2)
  ) u_acc (
    .i_clk     (i_clk),
    .i_clear   (w_clr),
    .i_add     (w_hs),
    .i_acc_clr (w_out_hs),
    .i_latch   (w_latch),
    .i_sum     (i_add_sum),
    .o_grad    (o_out_grad)
  );

endmodule
